// File: rtl/keybank_if.sv
// Key-bank signal bundle: raw key levels and mode in, conditioned levels and pulses out.
// The slave modport is the keybank side and the master modport is the driving side.
interface keybank_if #(
    parameter int N = 4
) ();
    logic [N-1:0] in;
    logic [N-1:0] mode;
    logic [N-1:0] state;
    logic [N-1:0] press;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] rep;
    logic         any;

    modport master (output in, mode, input state, press, rise, fall, rep, any);
    modport slave  (input in, mode, output state, press, rise, fall, rep, any);
endinterface

// File: rtl/keybank.sv
// N-channel push-button conditioner: sync, hysteretic integrator debounce, edge pulses,
// per-channel toggle level and typematic auto-repeat.
module keybank #(
    parameter int N        = 4,
    parameter int CW       = 8,
    parameter int TH_ON    = 200,
    parameter int TH_OFF   = 50,
    parameter int HW       = 24,
    parameter int HOLD_CYC = 12000000,
    parameter int REP_CYC  = 2000000
) (
    input  logic     clk,
    input  logic     rst,
    keybank_if.slave kb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RPT  = 2'd2
    } rpt_e;

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] TH_ON_C  = CW'(TH_ON);
    localparam logic [CW-1:0] TH_OFF_C = CW'(TH_OFF);
    localparam logic [HW-1:0] HC_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_C   = HW'(HOLD_CYC);
    localparam logic [HW-1:0] REP_C    = HW'(REP_CYC);

    logic [N-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]  state_q, state_d, tog_q, tog_d;
    logic [N-1:0]  rise_q, rise_d, fall_q, fall_d, rep_q, rep_d;
    logic [N-1:0]  set_s, clr_s;
    logic          any_q, any_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [HW-1:0] hc_q  [N];
    logic [HW-1:0] hc_d  [N];
    rpt_e          fsm_q [N];
    rpt_e          fsm_d [N];

    // State register for every channel; reset clears everything including the toggle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            tog_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            rep_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
                hc_q[i]  <= '0;
                fsm_q[i] <= IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            tog_q   <= tog_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rep_q   <= rep_d;
            any_q   <= any_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
                hc_q[i]  <= hc_d[i];
                fsm_q[i] <= fsm_d[i];
            end
        end
    end

    // Next-state logic: integrator, hysteresis, edges, toggle and repeat FSM per channel.
    always_comb begin
        sync1_d = kb.in;
        sync2_d = sync1_q;
        state_d = state_q;
        tog_d   = tog_q;
        rise_d  = '0;
        fall_d  = '0;
        rep_d   = '0;
        set_s   = '0;
        clr_s   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            hc_d[i]  = hc_q[i];
            fsm_d[i] = fsm_q[i];

            if (sync2_q[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (!sync2_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            if (cnt_d[i] >= TH_ON_C) begin
                state_d[i] = 1'b1;
            end else if (cnt_d[i] <= TH_OFF_C) begin
                state_d[i] = 1'b0;
            end else begin
                state_d[i] = state_q[i];
            end

            set_s[i]  = state_d[i] & ~state_q[i];
            clr_s[i]  = ~state_d[i] & state_q[i];
            rise_d[i] = set_s[i];
            fall_d[i] = clr_s[i];
            if (set_s[i] && kb.mode[i]) begin
                tog_d[i] = ~tog_q[i];
            end else begin
                tog_d[i] = tog_q[i];
            end

            // hc counts 0..limit inclusive, so repeat pulses are limit+1 cycles apart.
            case (fsm_q[i])
                IDLE: begin
                    hc_d[i] = '0;
                    if (set_s[i]) begin
                        fsm_d[i] = WAIT;
                    end else begin
                        fsm_d[i] = IDLE;
                    end
                end
                WAIT: begin
                    if (clr_s[i]) begin
                        fsm_d[i] = IDLE;
                        hc_d[i]  = '0;
                    end else if (hc_q[i] == HOLD_C) begin
                        fsm_d[i] = RPT;
                        hc_d[i]  = '0;
                        rep_d[i] = 1'b1;
                    end else begin
                        hc_d[i]  = hc_q[i] + HC_ONE;
                    end
                end
                RPT: begin
                    if (clr_s[i]) begin
                        fsm_d[i] = IDLE;
                        hc_d[i]  = '0;
                    end else if (hc_q[i] == REP_C) begin
                        hc_d[i]  = '0;
                        rep_d[i] = 1'b1;
                    end else begin
                        hc_d[i]  = hc_q[i] + HC_ONE;
                    end
                end
                default: begin
                    fsm_d[i] = IDLE;
                    hc_d[i]  = '0;
                end
            endcase
        end
        any_d = |state_d;
    end

    assign kb.state = state_q;
    assign kb.press = (kb.mode & tog_q) | (~kb.mode & state_q);
    assign kb.rise  = rise_q;
    assign kb.fall  = fall_q;
    assign kb.rep   = rep_q;
    assign kb.any   = any_q;

endmodule

// File: tb/tb_keybank.sv
// Scoreboard bench for keybank: stimulus queues expected pulses and level samples by cycle,
// a negedge monitor pops and compares them.
module tb_keybank;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        int cyc;
        int sel;
        int val;
    } lv_t;

    ev_t exp_q[$];
    lv_t lv_q[$];

    keybank_if #(.N(2)) kb_if ();

    keybank #(
        .N(2), .CW(4), .TH_ON(12), .TH_OFF(4), .HW(8), .HOLD_CYC(20), .REP_CYC(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kb (kb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string lv_name(input int sel);
        case (sel)
            0:       return "state";
            1:       return "press";
            2:       return "any";
            3:       return "all_outputs";
            default: return "queues_drained";
        endcase
    endfunction

    // Monitor: every pulse must match the head of the event queue; level samples due now are checked.
    always @(negedge clk) begin : monitor
        ev_t  e;
        lv_t  l;
        logic p;
        int   act;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
                p = (k == 0) ? kb_if.rise[ch] : ((k == 1) ? kb_if.fall[ch] : kb_if.rep[ch]);
                if (p) begin
                    n_tests = n_tests + 1;
                    if (exp_q.size() == 0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL pulse cyc=%0d: actual ch=%0d kind=%0d, required no pulse", cyc, ch, k);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.ch != ch || e.kind != k) begin
                            n_fail = n_fail + 1;
                            $display("FAIL pulse: actual cyc=%0d ch=%0d kind=%0d, required cyc=%0d ch=%0d kind=%0d",
                                     cyc, ch, k, e.cyc, e.ch, e.kind);
                        end
                    end
                end
            end
        end
        while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
            l = lv_q.pop_front();
            case (l.sel)
                0:       act = int'(kb_if.state);
                1:       act = int'(kb_if.press);
                2:       act = int'(kb_if.any);
                3:       act = int'({kb_if.state, kb_if.press, kb_if.rise, kb_if.fall, kb_if.rep, kb_if.any});
                default: act = exp_q.size() + lv_q.size();
            endcase
            n_tests = n_tests + 1;
            if (l.cyc != cyc || act != l.val) begin
                n_fail = n_fail + 1;
                $display("FAIL %s cyc=%0d (due %0d): actual=%0h required=%0h", lv_name(l.sel), cyc, l.cyc, act, l.val);
            end
        end
    end

    task automatic ev(input int c, input int ch, input int k);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic lv(input int c, input int sel, input int val);
        lv_t l;
        l.cyc = c;
        l.sel = sel;
        l.val = val;
        lv_q.push_back(l);
    endtask

    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc        = 0;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        kb_if.in   = 2'b00;
        kb_if.mode = 2'b00;

        // Reset state.
        lv(1, 3, 0); lv(2, 3, 0); lv(3, 3, 0);
        at(3);
        rst = 1'b0;

        // Clean press on ch0, held 40 cycles; release lands on a repeat slot.
        ev(24, 0, 0); ev(45, 0, 2); ev(51, 0, 2); ev(57, 0, 2); ev(63, 0, 1);
        lv(23, 0, 0); lv(24, 0, 1); lv(24, 1, 1); lv(24, 2, 1);
        lv(62, 0, 1); lv(63, 0, 0); lv(63, 2, 0);
        at(10);
        kb_if.in = 2'b01;
        at(50);
        kb_if.in = 2'b00;

        // Bounce: 3 high / 2 low for 60 cycles, then sustained low.
        ev(120, 0, 0); ev(140, 0, 1);
        lv(119, 0, 0); lv(120, 0, 1); lv(139, 0, 1); lv(140, 0, 0);
        for (int j = 0; j < 60; j++) begin
            at(70 + j);
            kb_if.in[0] = ((j % 5) < 3) ? 1'b1 : 1'b0;
        end
        at(130);
        kb_if.in[0] = 1'b0;

        // Toggle mode on ch1, first press/release.
        ev(174, 1, 0); ev(189, 1, 1);
        lv(173, 1, 0); lv(174, 1, 2); lv(190, 1, 2); lv(190, 0, 0);
        at(155);
        kb_if.mode = 2'b10;
        at(160);
        kb_if.in[1] = 1'b1;
        at(176);
        kb_if.in[1] = 1'b0;

        // Second toggle press, mode switches mid-hold, both channels repeating, async reset.
        ev(224, 1, 0); ev(234, 0, 0); ev(245, 1, 2); ev(251, 1, 2);
        ev(255, 0, 2); ev(257, 1, 2); ev(261, 0, 2); ev(263, 1, 2);
        lv(223, 1, 2); lv(224, 1, 0); lv(224, 0, 2); lv(230, 1, 2); lv(232, 1, 0);
        lv(250, 1, 3); lv(264, 3, 0); lv(265, 3, 0); lv(266, 3, 0);
        at(210);
        kb_if.in[1] = 1'b1;
        at(220);
        kb_if.in[0] = 1'b1;
        at(230);
        kb_if.mode = 2'b00;
        at(232);
        kb_if.mode = 2'b10;
        at(240);
        kb_if.mode = 2'b00;
        at(264);
        rst      = 1'b1;
        kb_if.in = 2'b00;
        at(267);
        rst = 1'b0;

        // Re-press after reset needs the full integration again.
        ev(284, 0, 0); ev(299, 0, 1);
        lv(283, 0, 0); lv(284, 0, 1); lv(310, 4, 0);
        at(270);
        kb_if.in[0] = 1'b1;
        at(286);
        kb_if.in[0] = 1'b0;

        at(311);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
